// File: rtl/eth_mac_pkg.sv
// eth_mac_pkg: constants and rx FSM state encoding shared by the Ethernet MAC rx/tx paths.
//   ETH_*        : framing bytes, CRC-32 polynomial and residue, minimum payload length
//   rx_state_t   : rx framing FSM state type with RX_* state constants
package eth_mac_pkg;
    localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  ETH_SFD_BYTE      = 8'hD5;
    localparam logic [31:0] ETH_CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC_RESIDUE   = 32'hDEBB20E3;
    localparam int          ETH_MIN_PAYLOAD   = 60;

    typedef logic [2:0] rx_state_t;
    localparam rx_state_t RX_IDLE     = 3'd0;
    localparam rx_state_t RX_PREAMBLE = 3'd1;
    localparam rx_state_t RX_PAYLOAD  = 3'd2;
    localparam rx_state_t RX_FLUSH    = 3'd3;
    localparam rx_state_t RX_DROP     = 3'd4;
endpackage

// File: rtl/eth_crc32_byte.sv
// eth_crc32_byte: combinational byte-serial CRC-32 step (reflected, LSB of data first).
//   crc      in  32  current CRC register
//   data     in   8  byte to absorb
//   crc_next out 32  CRC register after absorbing data
module eth_crc32_byte
    import eth_mac_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);
    always_comb begin
        crc_next = crc;
        for (int i = 0; i < 8; i++)
            crc_next = (crc_next >> 1) ^ ((crc_next[0] ^ data[i]) ? ETH_CRC_POLY_REFL : 32'h0);
    end
endmodule

// File: rtl/eth_mac_rx_parser.sv
// eth_mac_rx_parser: GMII rx framing - strips preamble/SFD and FCS, checks CRC, emits AXI-Stream bytes.
//   clk_125, reset_n          : receive clock, async active-low reset
//   gmii_rxd/rxdv/rxer/rx_ce  : GMII byte, frame valid, PHY error, byte strobe
//   m_rx_axis_t*              : payload stream; tuser on the tlast beat flags a bad frame
//   s_rx_axis_trdy            : FIFO ready
//   stat_rx_good/stat_rx_bad  : one-cycle per-frame status pulses
module eth_mac_rx_parser
    import eth_mac_pkg::*;
#(
    parameter int MIN_PAYLOAD  = ETH_MIN_PAYLOAD,
    parameter int MAX_PREAMBLE = 7
) (
    input  logic       clk_125,
    input  logic       reset_n,
    input  logic [7:0] gmii_rxd,
    input  logic       gmii_rxdv,
    input  logic       gmii_rxer,
    input  logic       gmii_rx_ce,
    output logic [7:0] m_rx_axis_tdata,
    output logic       m_rx_axis_tvalid,
    output logic       m_rx_axis_tlast,
    output logic       m_rx_axis_tuser,
    input  logic       s_rx_axis_trdy,
    output logic       stat_rx_good,
    output logic       stat_rx_bad
);
    rx_state_t   state;
    logic [39:0] sh;
    logic [2:0]  lcnt;
    logic [31:0] crc;
    logic [31:0] crc_nxt;
    logic [10:0] cnt;
    logic [7:0]  pcnt;
    logic        err;
    logic        ifg;
    logic        armed;
    logic        lost;
    logic        bad_end;
    logic        ifg_now;

    eth_crc32_byte u_crc (.crc(crc), .data(gmii_rxd), .crc_next(crc_nxt));

    // A non-last beat still pending at a byte strobe was never taken by the FIFO.
    assign lost    = m_rx_axis_tvalid & ~m_rx_axis_tlast & ~s_rx_axis_trdy;
    // cnt includes the 4 FCS bytes, hence the +4 on the runt threshold.
    assign bad_end = err | lost | (crc != ETH_CRC_RESIDUE) | (int'(cnt) < MIN_PAYLOAD + 4);
    assign ifg_now = ifg | (gmii_rx_ce & gmii_rxdv);

    always_ff @(posedge clk_125 or negedge reset_n) begin
        if (!reset_n) begin
            state            <= RX_IDLE;
            sh               <= '0;
            lcnt             <= '0;
            crc              <= '1;
            cnt              <= '0;
            pcnt             <= '0;
            err              <= 1'b0;
            ifg              <= 1'b0;
            armed            <= 1'b0;
            m_rx_axis_tdata  <= '0;
            m_rx_axis_tvalid <= 1'b0;
            m_rx_axis_tlast  <= 1'b0;
            m_rx_axis_tuser  <= 1'b0;
            stat_rx_good     <= 1'b0;
            stat_rx_bad      <= 1'b0;
        end else begin
            stat_rx_good <= 1'b0;
            stat_rx_bad  <= 1'b0;
            // After reset, wait for an inter-frame gap so a frame in progress is not parsed.
            if (gmii_rx_ce && !gmii_rxdv)
                armed <= 1'b1;
            if (m_rx_axis_tvalid && s_rx_axis_trdy && !m_rx_axis_tlast)
                m_rx_axis_tvalid <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (gmii_rx_ce && gmii_rxdv && armed) begin
                        if (gmii_rxd == ETH_PREAMBLE_BYTE) begin
                            state <= RX_PREAMBLE;
                            pcnt  <= 8'd1;
                        end else begin
                            state       <= RX_DROP;
                            stat_rx_bad <= 1'b1;
                        end
                    end
                end
                RX_PREAMBLE: begin
                    if (gmii_rx_ce) begin
                        if (!gmii_rxdv)
                            state <= RX_IDLE;
                        else if (gmii_rxd == ETH_SFD_BYTE) begin
                            state <= RX_PAYLOAD;
                            crc   <= '1;
                            err   <= 1'b0;
                            lcnt  <= '0;
                            cnt   <= '0;
                        end else if (gmii_rxd == ETH_PREAMBLE_BYTE && int'(pcnt) < MAX_PREAMBLE)
                            pcnt <= pcnt + 8'd1;
                        else begin
                            state       <= RX_DROP;
                            stat_rx_bad <= 1'b1;
                        end
                    end
                end
                RX_PAYLOAD: begin
                    if (gmii_rx_ce) begin
                        if (lost)
                            err <= 1'b1;
                        if (gmii_rxdv) begin
                            crc <= crc_nxt;
                            sh  <= {sh[31:0], gmii_rxd};
                            cnt <= cnt + 11'(cnt != 11'h7FF);
                            if (gmii_rxer)
                                err <= 1'b1;
                            if (lcnt == 3'd5) begin
                                m_rx_axis_tdata  <= sh[39:32];
                                m_rx_axis_tvalid <= 1'b1;
                            end else
                                lcnt <= lcnt + 3'd1;
                        end else if (lcnt == 3'd5) begin
                            // The four youngest entries are the FCS; the oldest is the last payload byte.
                            m_rx_axis_tdata  <= sh[39:32];
                            m_rx_axis_tvalid <= 1'b1;
                            m_rx_axis_tlast  <= 1'b1;
                            m_rx_axis_tuser  <= bad_end;
                            ifg              <= 1'b0;
                            state            <= RX_FLUSH;
                        end else begin
                            stat_rx_bad <= 1'b1;
                            state       <= RX_IDLE;
                        end
                    end
                end
                RX_FLUSH: begin
                    if (gmii_rx_ce && gmii_rxdv)
                        ifg <= 1'b1;
                    if (s_rx_axis_trdy) begin
                        m_rx_axis_tvalid <= 1'b0;
                        m_rx_axis_tlast  <= 1'b0;
                        m_rx_axis_tuser  <= 1'b0;
                        stat_rx_good     <= ~m_rx_axis_tuser;
                        stat_rx_bad      <= m_rx_axis_tuser | ifg_now;
                        ifg              <= 1'b0;
                        state            <= ifg_now ? RX_DROP : RX_IDLE;
                    end
                end
                RX_DROP: begin
                    if (gmii_rx_ce && !gmii_rxdv)
                        state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_mac_rx_parser.sv
// tb_eth_mac_rx_parser: scoreboard bench for the rx framing stage.
module tb_eth_mac_rx_parser;
    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
    } beat_t;

    logic       clk_125 = 1'b0;
    logic       reset_n;
    logic [7:0] gmii_rxd;
    logic       gmii_rxdv;
    logic       gmii_rxer;
    logic       gmii_rx_ce;
    logic [7:0] m_rx_axis_tdata;
    logic       m_rx_axis_tvalid;
    logic       m_rx_axis_tlast;
    logic       m_rx_axis_tuser;
    logic       s_rx_axis_trdy;
    logic       stat_rx_good;
    logic       stat_rx_bad;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fs = 0;
    int rdy_lo = 0;
    int rdy_len = 0;
    int good_cnt = 0;
    int bad_cnt = 0;
    int hold_cnt = 0;
    int saw_valid = 0;
    int first_vis = -1;
    int last_acc = 0;
    int ce_div_g = 1;
    bit prev_acc = 0;
    beat_t sb[$];
    logic [7:0] pl[$];

    always #4 clk_125 = ~clk_125;

    eth_mac_rx_parser #(.MIN_PAYLOAD(60), .MAX_PREAMBLE(7)) dut (
        .clk_125(clk_125), .reset_n(reset_n),
        .gmii_rxd(gmii_rxd), .gmii_rxdv(gmii_rxdv), .gmii_rxer(gmii_rxer), .gmii_rx_ce(gmii_rx_ce),
        .m_rx_axis_tdata(m_rx_axis_tdata), .m_rx_axis_tvalid(m_rx_axis_tvalid),
        .m_rx_axis_tlast(m_rx_axis_tlast), .m_rx_axis_tuser(m_rx_axis_tuser),
        .s_rx_axis_trdy(s_rx_axis_trdy), .stat_rx_good(stat_rx_good), .stat_rx_bad(stat_rx_bad)
    );

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic bit rdy_low(input int f);
        return f >= rdy_lo && f < rdy_lo + rdy_len;
    endfunction

    // One clock: drive inputs, consume any beat the FIFO takes at the coming edge.
    task automatic step(input logic dv, input logic [7:0] d, input logic ce, input logic er);
        logic  rdy;
        beat_t e;
        rdy = !rdy_low(fs);
        gmii_rxdv = dv;
        gmii_rxd = d;
        gmii_rx_ce = ce;
        gmii_rxer = er;
        s_rx_axis_trdy = rdy;
        good_cnt += int'(stat_rx_good);
        bad_cnt += int'(stat_rx_bad);
        if (m_rx_axis_tvalid) saw_valid++;
        if (m_rx_axis_tvalid && first_vis < 0) first_vis = cyc;
        if (m_rx_axis_tvalid && m_rx_axis_tlast && !rdy) hold_cnt++;
        if (m_rx_axis_tvalid && rdy) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat got d=%02h l=%0b want no beat", m_rx_axis_tdata, m_rx_axis_tlast);
            end else begin
                e = sb.pop_front();
                if (m_rx_axis_tdata !== e.d || m_rx_axis_tlast !== e.l || (e.l && m_rx_axis_tuser !== e.u)) begin
                    errors++;
                    $display("FAIL beat got d=%02h l=%0b u=%0b want d=%02h l=%0b u=%0b",
                             m_rx_axis_tdata, m_rx_axis_tlast, m_rx_axis_tuser, e.d, e.l, e.u);
                end
                if (!e.l) begin
                    if (rdy_len == 0 && prev_acc) begin
                        checks++;
                        if (cyc - last_acc != ce_div_g) begin
                            errors++;
                            $display("FAIL beat_spacing got %0d want %0d", cyc - last_acc, ce_div_g);
                        end
                    end
                    prev_acc = 1;
                    last_acc = cyc;
                end
            end
        end
        @(posedge clk_125);
        #1;
        cyc++;
        fs++;
    endtask

    task automatic idle_cycle(input int ce_div);
        if (ce_div == 2) step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic send_frame(input int ce_div, input int flip);
        logic [7:0]  fr[$];
        logic [31:0] c;
        logic [7:0]  b;
        beat_t       e;
        int          n;
        int          s0;
        logic        u;
        n = pl.size();
        c = '1;
        foreach (pl[i]) c = crc_byte(c, pl[i]);
        c = ~c;
        fr = {};
        repeat (7) fr.push_back(8'h55);
        fr.push_back(8'hD5);
        for (int i = 0; i < n; i++) begin
            b = pl[i];
            if (i == flip) b = b ^ 8'h10;
            fr.push_back(b);
        end
        for (int j = 0; j < 4; j++) fr.push_back(c[8*j +: 8]);
        u = (n < 60) || (flip >= 0);
        for (int k = 0; k < n - 1; k++)
            if (rdy_low(8 + k + 6)) u = 1'b1;
        good_cnt = 0;
        bad_cnt = 0;
        hold_cnt = 0;
        fs = 0;
        first_vis = -1;
        prev_acc = 0;
        ce_div_g = ce_div;
        s0 = 0;
        for (int i = 0; i < fr.size(); i++) begin
            if (i >= 8 && i < 8 + n && (i == 8 + n - 1 || !rdy_low(i + 6))) begin
                e.d = fr[i];
                e.l = (i == 8 + n - 1);
                e.u = u;
                sb.push_back(e);
            end
            if (ce_div == 2) step(1'b1, fr[i], 1'b0, 1'b0);
            if (i == 8) s0 = cyc;
            step(1'b1, fr[i], 1'b1, 1'b0);
        end
        for (int t = 0; t < 40 && sb.size() > 0; t++) idle_cycle(ce_div);
        repeat (3) idle_cycle(ce_div);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d beats left want 0", sb.size());
            sb.delete();
        end
        checks++;
        if (good_cnt != (u ? 0 : 1) || bad_cnt != (u ? 1 : 0)) begin
            errors++;
            $display("FAIL stats got good=%0d bad=%0d want good=%0d bad=%0d", good_cnt, bad_cnt, u ? 0 : 1, u ? 1 : 0);
        end
        checks++;
        if (first_vis - s0 != 5 * ce_div + 1) begin
            errors++;
            $display("FAIL latency got %0d want %0d", first_vis - s0, 5 * ce_div + 1);
        end
    endtask

    task automatic set_count_payload(input int n, input logic [7:0] base);
        pl = {};
        for (int i = 0; i < n; i++) pl.push_back(base + 8'(i));
    endtask

    task automatic test_reset;
        checks++;
        if ({m_rx_axis_tdata, m_rx_axis_tvalid, m_rx_axis_tlast, m_rx_axis_tuser, stat_rx_good, stat_rx_bad} !== 14'h0) begin
            errors++;
            $display("FAIL reset_outputs got %04h want 0000",
                     {m_rx_axis_tdata, m_rx_axis_tvalid, m_rx_axis_tlast, m_rx_axis_tuser, stat_rx_good, stat_rx_bad});
        end
        reset_n = 1'b1;
        repeat (3) idle_cycle(1);
    endtask

    task automatic test_good_1g;
        set_count_payload(60, 8'h00);
        send_frame(1, -1);
    endtask

    task automatic test_bit_flip;
        set_count_payload(60, 8'h00);
        send_frame(1, 10);
    endtask

    task automatic test_100m;
        set_count_payload(60, 8'h00);
        send_frame(2, -1);
    endtask

    task automatic test_runt;
        set_count_payload(20, 8'hA0);
        send_frame(1, -1);
    endtask

    task automatic test_bad_preamble;
        good_cnt = 0;
        bad_cnt = 0;
        saw_valid = 0;
        step(1'b1, 8'h55, 1'b1, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        step(1'b1, 8'h3C, 1'b1, 1'b0);
        repeat (8) step(1'b1, 8'h11, 1'b1, 1'b0);
        repeat (4) idle_cycle(1);
        checks++;
        if (saw_valid != 0 || good_cnt != 0 || bad_cnt != 1) begin
            errors++;
            $display("FAIL bad_preamble got valid=%0d good=%0d bad=%0d want 0 0 1", saw_valid, good_cnt, bad_cnt);
        end
        set_count_payload(60, 8'h40);
        send_frame(1, -1);
    endtask

    task automatic test_trdy_gap;
        rdy_lo = 30;
        rdy_len = 3;
        set_count_payload(60, 8'h00);
        send_frame(1, -1);
        rdy_len = 0;
    endtask

    task automatic test_tlast_hold;
        rdy_lo = 73;
        rdy_len = 5;
        set_count_payload(60, 8'h00);
        send_frame(1, -1);
        checks++;
        if (hold_cnt != 5) begin
            errors++;
            $display("FAIL tlast_hold got %0d cycles want 5", hold_cnt);
        end
        rdy_len = 0;
    endtask

    task automatic test_reset_midframe;
        fs = 0;
        rdy_lo = 0;
        rdy_len = 100000;
        repeat (7) step(1'b1, 8'h55, 1'b1, 1'b0);
        step(1'b1, 8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
        reset_n = 1'b0;
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        checks++;
        if ({m_rx_axis_tdata, m_rx_axis_tvalid, m_rx_axis_tlast, m_rx_axis_tuser, stat_rx_good, stat_rx_bad} !== 14'h0) begin
            errors++;
            $display("FAIL midframe_reset got %04h want 0000",
                     {m_rx_axis_tdata, m_rx_axis_tvalid, m_rx_axis_tlast, m_rx_axis_tuser, stat_rx_good, stat_rx_bad});
        end
        step(1'b1, 8'hAB, 1'b1, 1'b0);
        reset_n = 1'b1;
        rdy_len = 0;
        good_cnt = 0;
        bad_cnt = 0;
        saw_valid = 0;
        repeat (3) step(1'b1, 8'h55, 1'b1, 1'b0);
        step(1'b1, 8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b1, 8'(i + 100), 1'b1, 1'b0);
        repeat (5) idle_cycle(1);
        checks++;
        if (saw_valid != 0 || good_cnt != 0 || bad_cnt != 0) begin
            errors++;
            $display("FAIL post_reset_ignore got valid=%0d good=%0d bad=%0d want 0 0 0", saw_valid, good_cnt, bad_cnt);
        end
        set_count_payload(60, 8'h80);
        send_frame(1, -1);
    endtask

    task automatic test_back_to_back;
        pl = {};
        for (int i = 0; i < 64; i++) pl.push_back(8'($urandom_range(0, 255)));
        send_frame(1, -1);
        pl = {};
        for (int i = 0; i < 100; i++) pl.push_back(8'($urandom_range(0, 255)));
        send_frame(1, -1);
    endtask

    initial begin
        reset_n = 1'b0;
        gmii_rxd = 8'h00;
        gmii_rxdv = 1'b0;
        gmii_rxer = 1'b0;
        gmii_rx_ce = 1'b1;
        s_rx_axis_trdy = 1'b1;
        repeat (3) @(posedge clk_125);
        #1;
        test_reset;
        test_good_1g;
        test_bit_flip;
        test_100m;
        test_runt;
        test_bad_preamble;
        test_trdy_gap;
        test_tlast_hold;
        test_reset_midframe;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/eth_mac_rx_parser.md
# eth_mac_rx_parser

Receive-path framing stage of the Ethernet MAC, between the RGMII receive adapter (DDR nibbles already assembled into GMII bytes) and the write side of the rx FIFO. It validates and strips preamble/SFD, computes CRC-32 over each frame, and strips the 4-byte FCS. It emits the payload as an AXI-Stream byte stream, with `tuser` on the `tlast` beat marking a bad frame.

## Interface
Parameters:
- `MIN_PAYLOAD`, 60: minimum bytes between SFD and FCS; shorter frames are runts.
- `MAX_PREAMBLE`, 7: maximum 0x55 bytes accepted before SFD.

Ports:
- `clk_125`  in  1  receive clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `gmii_rxd`  in  8  received byte, LSB first on wire.
- `gmii_rxdv`  in  1  frame-active qualifier (RGMII rxctl rising-edge value).
- `gmii_rxer`  in  1  PHY error (rxdv XOR rxctl falling-edge value).
- `gmii_rx_ce`  in  1  byte strobe: 1 every cycle at 1G, 1 every 2nd cycle at 10/100. All byte state advances only when set.
- `m_rx_axis_tdata`  out  8  payload byte.
- `m_rx_axis_tvalid`  out  1  beat valid.
- `m_rx_axis_tlast`  out  1  last payload byte of the frame.
- `m_rx_axis_tuser`  out  1  bad frame; meaningful only with `tlast`.
- `s_rx_axis_trdy`  in  1  FIFO ready.
- `stat_rx_good`  out  1  one-cycle pulse per good frame delivered.
- `stat_rx_bad`  out  1  one-cycle pulse per bad or dropped frame.

## Operation
- FSM states:
  - IDLE: on ce&rxdv, byte 0x55 → PREAMBLE; any other byte → DROP.
  - PREAMBLE: counts 0x55 bytes. 0xD5 → PAYLOAD, CRC reset to 0xFFFFFFFF. Preamble count > `MAX_PREAMBLE`, any other byte, or rxdv low → DROP (or IDLE if rxdv low).
  - PAYLOAD: each ce&rxdv byte updates the CRC and enters a 5-deep byte delay line. When the line is full, the oldest byte is presented as a beat. rxdv low ends the frame → FLUSH.
  - FLUSH: the oldest entry is the last payload byte; the other 4 entries are FCS and are discarded. Present the last payload byte with tlast=1 and tuser=err, hold until accepted, then → IDLE.
  - DROP: discard until rxdv low → IDLE; pulse `stat_rx_bad` once on entry.
- Error flag `err`: cleared at SFD. Set by any of:
  - rxer during PAYLOAD;
  - CRC residue ≠ 32'hDEBB20E3 after the final byte (residue taken before final inversion, FCS included);
  - payload count < `MIN_PAYLOAD`;
  - overflow.
- Payload counter saturates at 2047. It counts bytes from SFD to the end of the frame, minus 4.
- Frame ending with ≤ 4 bytes after SFD: no beats emitted; `stat_rx_bad` pulses; → IDLE.
- Beat handshake:
  - Non-last beats are valid for exactly one ce period. If trdy is low for that whole period, the byte is lost and `err` is set (the MAC cannot back-pressure the PHY).
  - The tlast beat holds until trdy is high.
- Stats: at tlast acceptance, pulse `stat_rx_good` if tuser=0, else `stat_rx_bad`.
- rxdv asserted while in FLUSH (IFG violation): bytes ignored, state → DROP after tlast is accepted.

## Timing
- Reset values: tdata=0, tvalid=0, tlast=0, tuser=0, stat pulses=0, FSM=IDLE, delay line empty, err=0.
- Latency at 1G (ce=1): payload byte k appears on tdata, registered, 5 cycles after it is sampled. The last payload beat appears 1 cycle after the first rxdv=0 sample.
- CRC update: one byte per ce, byte-serial, reflected polynomial 32'hEDB88320. The residue check uses the register value after the last FCS byte.
- Reset asserted mid-frame: outputs go to reset values immediately with no tlast. Bytes are then ignored until rxdv low followed by a new preamble.
- Simultaneous final byte and rxdv fall cannot occur: rxdv is sampled per byte.

## Structure
- Shared package `eth_mac_pkg`:
  - `ETH_PREAMBLE_BYTE` = 8'h55
  - `ETH_SFD_BYTE` = 8'hD5
  - `ETH_CRC_POLY_REFL` = 32'hEDB88320
  - `ETH_CRC_RESIDUE` = 32'hDEBB20E3
  - `ETH_MIN_PAYLOAD` = 60
  - rx FSM state enum
- Sub-module `eth_crc32_byte`: combinational next-CRC from current CRC and one byte. Shared with the tx path.

## Test plan
- 7×0x55, 0xD5, 60 bytes 0x00..0x3B, correct FCS, ce=1, trdy=1 → 60 beats 0x00..0x3B, tlast on 0x3B, tuser=0, `stat_rx_good`=1 pulse, first beat 5 cycles after byte 0x00 sampled.
- Same frame with one payload bit flipped → 60 beats, tuser=1 on tlast, `stat_rx_bad` pulse.
- Same frame at ce every 2nd cycle (100M) → identical beat sequence, beats spaced 2 cycles, tuser=0.
- 20-byte payload with valid FCS → 20 beats, tuser=1 (runt).
- 0x55, 0x55, 0x3C, … → no beats, `stat_rx_bad` pulse, next valid frame received correctly.
- trdy low for 3 cycles mid-frame → tuser=1 on tlast. Then trdy low at tlast → tlast beat held until trdy=1. reset_n low mid-frame → all outputs 0 next edge.
